// File: rtl/frequency_generator.sv
// Parameterised clock divider: registered square-wave OutputCLK of inputFrequency/N Hz
// plus a one-cycle OutputTick in the InputCLK domain on each OutputCLK rise.
module frequency_generator #(
    parameter int inputFrequency = 50000000,
    parameter int frequency      = 50,
    parameter int bitsNumber     = 21
) (
    input  logic InputCLK,
    input  logic Reset,
    output logic OutputCLK,
    output logic OutputTick
);

    // Divisor guarded so a bad frequency reaches the fatal check below
    // instead of a divide-by-zero during elaboration.
    localparam int N    = inputFrequency / ((frequency < 1) ? 1 : frequency);
    localparam int LOW  = N / 2;
    localparam int HIGH = N - LOW;

    localparam longint CNT_MAX = (longint'(1) << bitsNumber) - 1;

    if (frequency < 1) begin : g_chk_frequency
        $fatal(1, "frequency_generator: frequency must be >= 1");
    end
    if (N < 2) begin : g_chk_ratio
        $fatal(1, "frequency_generator: inputFrequency/frequency must be >= 2");
    end
    if (longint'(HIGH) - 1 > CNT_MAX) begin : g_chk_width
        $fatal(1, "frequency_generator: bitsNumber too small for HIGH-1");
    end

    localparam logic [bitsNumber-1:0] LOW_LAST  = bitsNumber'(LOW - 1);
    localparam logic [bitsNumber-1:0] HIGH_LAST = bitsNumber'(HIGH - 1);

    // Power-up values let the block run with Reset tied low.
    logic [bitsNumber-1:0] cnt_q  = '0;
    logic                  clk_q  = 1'b0;
    logic                  tick_q = 1'b0;
    logic [bitsNumber-1:0] cnt_d;
    logic                  clk_d;
    logic                  tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (!clk_q) begin
            if (cnt_q == LOW_LAST) begin
                cnt_d  = '0;
                clk_d  = 1'b1;
                tick_d = 1'b1;
            end
        end else begin
            if (cnt_q == HIGH_LAST) begin
                cnt_d = '0;
                clk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge InputCLK) begin
        if (Reset) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign OutputCLK  = clk_q;
    assign OutputTick = tick_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator at N=10, N=9, N=2 and an unreset N=6 instance;
// expected {OutputCLK,OutputTick} are queued at drive time and compared after each edge.
module tb_frequency_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r10 = 1'b1;
    logic r9  = 1'b1;
    logic r2  = 1'b1;
    logic c10, t10, c9, t9, c2, t2, cn, tn;

    frequency_generator #(.inputFrequency(100), .frequency(10), .bitsNumber(4)) u_n10 (
        .InputCLK(clk), .Reset(r10), .OutputCLK(c10), .OutputTick(t10));
    frequency_generator #(.inputFrequency(90), .frequency(10), .bitsNumber(3)) u_n9 (
        .InputCLK(clk), .Reset(r9), .OutputCLK(c9), .OutputTick(t9));
    frequency_generator #(.inputFrequency(2), .frequency(1), .bitsNumber(1)) u_n2 (
        .InputCLK(clk), .Reset(r2), .OutputCLK(c2), .OutputTick(t2));
    frequency_generator #(.inputFrequency(60), .frequency(10), .bitsNumber(2)) u_nr (
        .InputCLK(clk), .Reset(1'b0), .OutputCLK(cn), .OutputTick(tn));

    int errors = 0;
    int checks = 0;

    // Edges since the last reset edge (or since time 0 for the unreset instance).
    int k10 = 0;
    int k9  = 0;
    int k2  = 0;
    int kn  = 0;

    logic [7:0] exp_q[$];

    function automatic logic [1:0] model(input int k, input int n);
        int p;
        p = k % n;
        return {p >= n / 2, p == n / 2};
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s at %0t: {clk,tick} observed=%b expected=%b", tag, $time, obs, expv);
        end
    endtask

    task automatic step(input logic [2:0] rst);
        logic [7:0] e;
        r10 = rst[0];
        r9  = rst[1];
        r2  = rst[2];
        k10 = rst[0] ? 0 : k10 + 1;
        k9  = rst[1] ? 0 : k9 + 1;
        k2  = rst[2] ? 0 : k2 + 1;
        kn  = kn + 1;
        exp_q.push_back({model(k10, 10), model(k9, 9), model(k2, 2), model(kn, 6)});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard underflow at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("n10", {c10, t10}, e[7:6]);
            chk("n9",  {c9, t9},   e[5:4]);
            chk("n2",  {c2, t2},   e[3:2]);
            chk("nr",  {cn, tn},   e[1:0]);
        end
        @(negedge clk);
    endtask

    initial begin
        int guard;
        // Power-up state before any edge.
        #1;
        chk("powerup_n10", {c10, t10}, 2'b00);
        chk("powerup_nr",  {cn, tn},   2'b00);

        repeat (3) step(3'b111);
        repeat (45) step(3'b000);

        // Reset N=10 for one cycle during its 3rd high cycle.
        guard = 0;
        while (k10 % 10 != 7 && guard < 20) begin
            step(3'b000);
            guard++;
        end
        checks++;
        assert (k10 % 10 == 7) else begin
            errors++;
            $error("FAIL midreset_align observed=%0d expected=7", k10 % 10);
        end
        chk("midreset_high", {c10, t10}, 2'b10);
        step(3'b001);
        chk("midreset_after", {c10, t10}, 2'b00);
        repeat (22) step(3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frequency_generator.md
Name: frequency_generator

Overview:
Parameterised clock divider. It derives a slow, square-wave enable clock of `frequency` Hz from the system clock `InputCLK`. Used by debouncers and other slow samplers; ButtonDebouncer instantiates it at 50 Hz with a 21-bit counter. It also provides a single-cycle tick, in the `InputCLK` domain, aligned to each rising edge of `OutputCLK`.

Parameters:
- `inputFrequency`, default 50000000: frequency of `InputCLK` in Hz.
- `frequency`, default 50: required `OutputCLK` frequency in Hz.
- `bitsNumber`, default 21: width of the internal cycle counter.

Ports:
- `InputCLK`, input, 1 bit: system clock. All logic is on its rising edge.
- `Reset`, input, 1 bit: synchronous, active-high reset. Tie to 0 where unused.
- `OutputCLK`, output, 1 bit: divided clock, registered, glitch-free.
- `OutputTick`, output, 1 bit: one `InputCLK` cycle high on each 0→1 transition of `OutputCLK`.

Behaviour:
- Interface: one clock (`InputCLK`). Reset (`Reset`) is synchronous and active-high.
- Derived constants (elaboration time):
  - `N = inputFrequency / frequency`, integer division.
  - `LOW = N / 2`, floor.
  - `HIGH = N - LOW`.
- Elaboration checks; any violation is a fatal error:
  - `frequency` ≥ 1.
  - `N` ≥ 2.
  - `HIGH - 1` ≤ 2^`bitsNumber` - 1.
- State:
  - counter `cnt` [`bitsNumber`-1:0].
  - output register `OutputCLK`.
  - tick register `OutputTick`.
  - All three have power-up/initial value 0, so the block works with `Reset` tied low.
- Reset: while `Reset`=1 at a rising edge, `cnt`←0, `OutputCLK`←0, `OutputTick`←0. Reset overrides everything and may be asserted mid-period; the next period restarts cleanly in the low phase.
- Low phase (`OutputCLK`=0), each rising edge:
  - If `cnt` = `LOW`-1: `cnt`←0, `OutputCLK`←1, `OutputTick`←1.
  - Else: `cnt`←`cnt`+1, `OutputTick`←0.
- High phase (`OutputCLK`=1), each rising edge:
  - If `cnt` = `HIGH`-1: `cnt`←0, `OutputCLK`←0.
  - Else: `cnt`←`cnt`+1.
  - `OutputTick`←0 in both cases.
- Resulting waveform:
  - After reset release, `OutputCLK` is low for exactly `LOW` cycles, then high for `HIGH` cycles, repeating.
  - Period is exactly `N` cycles.
  - Duty cycle is exactly 50% for even `N`; for odd `N` the high phase is one cycle longer.
  - The division remainder (`inputFrequency` mod `frequency`) is discarded, so the output frequency is `inputFrequency`/`N`.
- `OutputTick` is high in the same cycle that `OutputCLK` first reads 1, for exactly one cycle per period.
- `cnt` never exceeds `HIGH`-1; no wrap-around past that bound is possible.
- Outputs come straight from flops, with no combinational path from any input.

Test Plan:
- `inputFrequency`=100, `frequency`=10 (N=10): hold `Reset` 3 cycles, release → `OutputCLK` 0 for 5 cycles, 1 for 5 cycles, repeated over 4 periods; `OutputTick` pulses once per period, 1 cycle wide, coincident with each rise.
- `inputFrequency`=90, `frequency`=10 (N=9) → low 4 cycles, high 5 cycles, period 9 across 3 periods.
- `inputFrequency`=2, `frequency`=1 (N=2) → `OutputCLK` toggles every cycle (0,1,0,1…); `OutputTick` high every other cycle.
- Mid-operation reset: N=10, assert `Reset` for 1 cycle during the 3rd high cycle → next edge `OutputCLK`=0, `OutputTick`=0; then a full 5-low/5-high pattern restarts.
- No reset (`Reset` tied 0), defaults 50 MHz→50 Hz with `bitsNumber`=21 → first rise after 500000 cycles, period 1000000 cycles, `cnt` max 499999.
- Elaboration check: `frequency`=60 with `inputFrequency`=100 (N=1), or `bitsNumber`=4 with N=100 → fatal error reported at elaboration.
